// File: rtl/assoc_argmax_seq_if.sv
// Handshake and result bus between the associative AND array and its argmax scanner.
`timescale 1ns/1ps
interface assoc_argmax_seq_if #(
  parameter int HV_DIM      = 50,
  parameter int NUM_CLASSES = 26,
  parameter int IDX_W       = 5,
  parameter int SCORE_W     = 6
);
  logic                          start;
  logic [NUM_CLASSES*HV_DIM-1:0] and_flat;
  logic                          busy;
  logic                          done;
  logic [IDX_W-1:0]              best_idx;
  logic [SCORE_W-1:0]            best_score;
  logic                          match;

  modport master (
    output start, and_flat,
    input  busy, done, best_idx, best_score, match
  );

  modport slave (
    input  start, and_flat,
    output busy, done, best_idx, best_score, match
  );
endinterface

// File: rtl/assoc_argmax_seq.sv
// Sequential argmax over the ANDed class hypervectors: one class popcounted per cycle,
// running maximum kept with lowest-index tie-break, result plus threshold match reported.
`timescale 1ns/1ps
module assoc_argmax_seq #(
  parameter int HV_DIM       = 50,
  parameter int NUM_CLASSES  = 26,
  parameter int IDX_W        = 5,
  parameter int SCORE_W      = 6,
  parameter int MATCH_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  assoc_argmax_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state, state_nxt;
  logic [HV_DIM-1:0]    cap [NUM_CLASSES];
  logic [IDX_W-1:0]     cnt;
  logic [SCORE_W-1:0]   run_max;
  logic [IDX_W-1:0]     run_idx;
  logic [IDX_W-1:0]     best_idx;
  logic [SCORE_W-1:0]   best_score;
  logic                 match;

  logic [SCORE_W-1:0]   pc;
  logic                 take_new;
  logic [SCORE_W-1:0]   cand_max;
  logic [IDX_W-1:0]     cand_idx;
  logic                 last;

  function automatic logic [SCORE_W-1:0] popcount(input logic [HV_DIM-1:0] v);
    logic [SCORE_W-1:0] s;
    s = '0;
    for (int i = 0; i < HV_DIM; i++) s = s + SCORE_W'(v[i]);
    return s;
  endfunction

  // Compare stage: the class under the counter against the running best
  assign pc       = popcount(cap[cnt]);
  assign take_new = (cnt == '0) || (pc > run_max);
  assign cand_max = take_new ? pc  : run_max;
  assign cand_idx = take_new ? cnt : run_idx;
  assign last     = (cnt == IDX_W'(NUM_CLASSES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) cap[k] <= '0;
      cnt        <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      best_idx   <= '0;
      best_score <= '0;
      match      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          for (int k = 0; k < NUM_CLASSES; k++) cap[k] <= bus.and_flat[k*HV_DIM +: HV_DIM];
          cnt     <= '0;
          run_max <= '0;
          run_idx <= '0;
        end
        SCAN: begin
          run_max <= cand_max;
          run_idx <= cand_idx;
          if (last) begin
            best_idx   <= cand_idx;
            best_score <= cand_max;
            match      <= (cand_max >= SCORE_W'(MATCH_THRESH));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result stage: done is the single DONE cycle, so reset clears it at once
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.best_idx   = best_idx;
  assign bus.best_score = best_score;
  assign bus.match      = match;

endmodule

// File: tb/tb_assoc_argmax_seq.sv
// Directed bench for assoc_argmax_seq: latency, argmax/tie-break, threshold, reset and restart.
`timescale 1ns/1ps
module tb_assoc_argmax_seq;
  localparam int HV = 50;
  localparam int NC = 26;
  localparam int IW = 5;
  localparam int SW = 6;

  typedef logic [NC*HV-1:0] flat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  assoc_argmax_seq_if #(.HV_DIM(HV), .NUM_CLASSES(NC), .IDX_W(IW), .SCORE_W(SW)) bus ();

  assoc_argmax_seq #(.HV_DIM(HV), .NUM_CLASSES(NC), .IDX_W(IW), .SCORE_W(SW), .MATCH_THRESH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  function automatic flat_t fill(input logic [HV-1:0] d);
    flat_t v;
    for (int k = 0; k < NC; k++) v[k*HV +: HV] = d;
    return v;
  endfunction

  // Caller sits 1 time unit after a rising edge; the capture edge is the next one.
  task automatic launch(input flat_t v);
    bus.and_flat = v;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.and_flat = '0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.best_idx !== 5'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.best_score); end
    checks++; if (bus.match !== 1'b0) begin failures++; $display("FAIL reset_match got=%0b exp=0", bus.match); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unique();
    flat_t v;
    int lat;
    v = fill(50'h1);
    v[2*HV +: HV]  = 50'h3F;
    v[16*HV +: HV] = 50'hFF;
    launch(v);
    wait_done(lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL unique_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd16) begin failures++; $display("FAIL unique_idx got=%0d exp=16", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd8) begin failures++; $display("FAIL unique_score got=%0d exp=8", bus.best_score); end
    checks++; if (bus.match !== 1'b1) begin failures++; $display("FAIL unique_match got=%0b exp=1", bus.match); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL unique_done_width got=%0b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL unique_busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_tie();
    flat_t v;
    int lat;
    v = '0;
    v[1*HV +: HV]  = 50'b1110;
    v[24*HV +: HV] = 50'b0111;
    launch(v);
    wait_done(lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL tie_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd1) begin failures++; $display("FAIL tie_idx got=%0d exp=1", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd3) begin failures++; $display("FAIL tie_score got=%0d exp=3", bus.best_score); end
    checks++; if (bus.match !== 1'b1) begin failures++; $display("FAIL tie_match got=%0b exp=1", bus.match); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int lat;
    launch('0);
    wait_done(lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL zero_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd0) begin failures++; $display("FAIL zero_idx got=%0d exp=0", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd0) begin failures++; $display("FAIL zero_score got=%0d exp=0", bus.best_score); end
    checks++; if (bus.match !== 1'b0) begin failures++; $display("FAIL zero_match got=%0b exp=0", bus.match); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%0b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_ignored_start();
    flat_t v;
    int pulses, first_at, busy_drop;
    logic [IW-1:0] r_idx;
    logic [SW-1:0] r_score;
    logic r_match;
    v = '0;
    v[25*HV +: HV] = {HV{1'b1}};
    pulses = 0; first_at = -1; busy_drop = 0;
    r_idx = '0; r_score = '0; r_match = 1'b0;
    launch(v);
    for (int e = 1; e <= 40; e++) begin
      if (e >= 5 && e <= 20) begin
        bus.start = 1'b1;
        for (int k = 0; k < NC; k++) bus.and_flat[k*HV +: HV] = 50'({$urandom(), $urandom()});
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (e <= 25 && bus.busy !== 1'b1) busy_drop++;
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = e; r_idx = bus.best_idx; r_score = bus.best_score; r_match = bus.match;
        end
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    checks++; if (first_at !== 26) begin failures++; $display("FAIL ign_latency got=%0d exp=26", first_at); end
    checks++; if (busy_drop !== 0) begin failures++; $display("FAIL ign_busy_drops got=%0d exp=0", busy_drop); end
    checks++; if (r_idx !== 5'd25) begin failures++; $display("FAIL ign_idx got=%0d exp=25", r_idx); end
    checks++; if (r_score !== 6'd50) begin failures++; $display("FAIL ign_score got=%0d exp=50", r_score); end
    checks++; if (r_match !== 1'b1) begin failures++; $display("FAIL ign_match got=%0b exp=1", r_match); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_idle_end got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_reset_midscan();
    flat_t v;
    int lat, saw_done;
    v = '0;
    v[3*HV +: HV] = 50'h7;
    launch(v);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b exp=0", bus.done); end
    checks++; if (bus.best_idx !== 5'd0) begin failures++; $display("FAIL rstmid_idx got=%0d exp=0", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd0) begin failures++; $display("FAIL rstmid_score got=%0d exp=0", bus.best_score); end
    checks++; if (bus.match !== 1'b0) begin failures++; $display("FAIL rstmid_match got=%0b exp=0", bus.match); end
    saw_done = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.done !== 1'b0) saw_done++; end
    rst_n = 1'b1;
    repeat (30) begin @(posedge clk); #1; if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done++; end
    checks++; if (saw_done !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", saw_done); end
    v = fill(50'h1);
    v[2*HV +: HV]  = 50'h3F;
    v[16*HV +: HV] = 50'hFF;
    launch(v);
    wait_done(lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL rstmid_re_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd16) begin failures++; $display("FAIL rstmid_re_idx got=%0d exp=16", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd8) begin failures++; $display("FAIL rstmid_re_score got=%0d exp=8", bus.best_score); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    flat_t va, vb;
    int lat, hold_bad;
    va = '0;
    va[1*HV +: HV]  = 50'b1110;
    va[24*HV +: HV] = 50'b0111;
    vb = fill(50'h3);
    vb[7*HV +: HV] = 50'h3FF;
    launch(va);
    wait_done(lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd1) begin failures++; $display("FAIL b2b_first_idx got=%0d exp=1", bus.best_idx); end
    // start raised during DONE must only take effect once the FSM is back in IDLE
    bus.and_flat = vb;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ignores_start got=%0b exp=0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.and_flat = '0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%0b exp=1", bus.busy); end
    hold_bad = 0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.best_idx !== 5'd1 || bus.best_score !== 6'd3 || bus.match !== 1'b1) hold_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL b2b_hold got=%0d exp=0", hold_bad); end
    checks++; if (lat !== 26) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=26", lat); end
    checks++; if (bus.best_idx !== 5'd7) begin failures++; $display("FAIL b2b_second_idx got=%0d exp=7", bus.best_idx); end
    checks++; if (bus.best_score !== 6'd10) begin failures++; $display("FAIL b2b_second_score got=%0d exp=10", bus.best_score); end
    checks++; if (bus.match !== 1'b1) begin failures++; $display("FAIL b2b_second_match got=%0b exp=1", bus.match); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unique();
    test_tie();
    test_all_zero();
    test_ignored_start();
    test_reset_midscan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
